ship_sprite_rom: RTL and testbench

Parametrised sprite line source for the ship renderer on BASYS3 VGA.
- Stores bitmaps for N_SHIPS ship types, each LINE_H rows of PIXEL_W pixels.
- Returns one horizontal line per request, optionally mirrored.
- Can also return one column as a line, for vertically placed ships. It builds the column by scanning all rows over several cycles under a request/valid handshake.
- Sits between the ship draw module and the VGA pixel pipeline.

---
 rtl/ship_pkg.sv | 31 +++
 rtl/ship_line_rom.sv | 36 +++
 rtl/ship_sprite_rom.sv | 147 ++++++++++++++
 tb/tb_ship_sprite_rom.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ship_pkg.sv
// Shared definitions for the ship sprite line source: default geometry, FSM state type and ROM image.
// No logic, so no latency.
// No handshake lives here; the package is only imported by the ROM and the top level.
package ship_pkg;

  localparam int SHIP_PIXEL_W = 48;
  localparam int SHIP_LINE_H  = 24;
  localparam int SHIP_N_SHIPS = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SCAN,
    OUT
  } ship_rom_state_t;

  // Bitmap image. Bit SHIP_PIXEL_W-1 is the leftmost pixel. Rows outside each hull are blank.
  function automatic logic [SHIP_PIXEL_W-1:0] get_ship_line(input int ship, input int row);
    logic [SHIP_PIXEL_W-1:0] line;
    line = '0;
    case (ship)
      0: if (row >= 3 && row <= 20) line = 48'h000111111000;
      1: if (row >= 4 && row <= 19) line = 48'h00FFFFFFFF00;
      2: if (row >= 1 && row <= 10) line = 48'h0F0F0F0F0F0F;
      3: if (row >= 6 && row <= 17) line = 48'h3FFFFFFFFFFC;
      default: line = '0;
    endcase
    return line;
  endfunction

endpackage

// File: rtl/ship_line_rom.sv
// Sprite row storage, addressed as ship_type*LINE_H + row.
// Latency is 1 cycle (registered read). An address past the last stored row reads as 0.
// There is no backpressure: a new address can be presented every cycle.
module ship_line_rom
  import ship_pkg::*;
#(
  parameter int PIXEL_W = SHIP_PIXEL_W,
  parameter int LINE_H  = SHIP_LINE_H,
  parameter int N_SHIPS = SHIP_N_SHIPS,
  parameter int ADDR_W  = $clog2(N_SHIPS * LINE_H)
) (
  input  logic               i_clk,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [PIXEL_W-1:0] o_data
);

  logic [PIXEL_W-1:0] w_data;

  // Address decode against the unrolled image; anything not matched stays 0.
  always_comb begin
    w_data = '0;
    for (int t = 0; t < N_SHIPS; t++) begin
      for (int r = 0; r < LINE_H; r++) begin
        if (i_addr == ADDR_W'(t * LINE_H + r)) begin
          w_data = PIXEL_W'(get_ship_line(t, r));
        end
      end
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    o_data <= w_data;
  end

endmodule

// File: rtl/ship_sprite_rom.sv
// Sprite line source: returns a ship row, or a column assembled from all rows. Either result can be mirrored.
// Latency: valid comes 2 cycles after the request for a row, and LINE_H+2 cycles after it for a column.
// Backpressure: busy is high while a request is in flight. A req seen while busy is dropped, not queued.
module ship_sprite_rom
  import ship_pkg::*;
#(
  parameter int PIXEL_W = SHIP_PIXEL_W,
  parameter int LINE_H  = SHIP_LINE_H,
  parameter int N_SHIPS = SHIP_N_SHIPS,
  parameter int IDX_W   = $clog2(PIXEL_W),
  parameter int TYPE_W  = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [TYPE_W-1:0]  ship_type,
  input  logic [IDX_W-1:0]   line_idx,
  input  logic               rotate,
  input  logic               mirror,
  output logic               busy,
  output logic               valid,
  output logic [PIXEL_W-1:0] line_pixels_out
);

  localparam int CNT_W  = $clog2(LINE_H + 1);
  localparam int ADDR_W = $clog2(N_SHIPS * LINE_H);

  ship_rom_state_t    r_state;
  logic [TYPE_W-1:0]  r_type;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mirror;
  logic               r_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_H-2:0]  r_col;

  logic [ADDR_W-1:0]  w_addr;
  logic [PIXEL_W-1:0] w_rom_q;
  logic [PIXEL_W-1:0] w_rom_rev;
  logic               w_bit;
  logic               w_type_oor;
  logic [LINE_H-1:0]  w_col_next;
  logic [LINE_H-1:0]  w_col_rev;
  logic [PIXEL_W-1:0] w_col_fwd;
  logic [PIXEL_W-1:0] w_col_mir;

  // In IDLE the ROM is addressed straight from the request inputs. The row is then ready in READ.
  // During SCAN the ROM walks rows from the counter instead.
  always_comb begin
    w_type_oor = (32'(ship_type) >= N_SHIPS);
    if (r_state == IDLE) begin
      w_addr = ADDR_W'(32'(ship_type) * LINE_H + 32'(line_idx));
    end else begin
      w_addr = ADDR_W'(32'(r_type) * LINE_H + 32'(r_cnt));
    end
  end

  ship_line_rom #(
    .PIXEL_W (PIXEL_W),
    .LINE_H  (LINE_H),
    .N_SHIPS (N_SHIPS),
    .ADDR_W  (ADDR_W)
  ) u_rom (
    .i_clk  (clk),
    .i_addr (w_addr),
    .o_data (w_rom_q)
  );

  // Bit reversal for mirroring, column bit pick, and placement of the column in the result.
  // With w_rom_rev[i] = w_rom_q[PIXEL_W-1-i], the column pick reduces to a plain index.
  always_comb begin
    w_rom_rev = '0;
    for (int i = 0; i < PIXEL_W; i++) begin
      w_rom_rev[i] = w_rom_q[PIXEL_W-1-i];
    end
    w_bit      = w_rom_rev[r_idx];
    w_col_next = {r_col, w_bit};
    w_col_rev  = '0;
    for (int i = 0; i < LINE_H; i++) begin
      w_col_rev[i] = w_col_next[LINE_H-1-i];
    end
    w_col_fwd = PIXEL_W'(w_col_next) << (PIXEL_W - LINE_H);
    w_col_mir = PIXEL_W'(w_col_rev) << (PIXEL_W - LINE_H);
  end

  // Request FSM. It holds the sampled request, counts rows during a column scan,
  // and registers the result together with a single-cycle valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_type          <= '0;
      r_idx           <= '0;
      r_mirror        <= 1'b0;
      r_zero          <= 1'b0;
      r_cnt           <= '0;
      r_col           <= '0;
      busy            <= 1'b0;
      valid           <= 1'b0;
      line_pixels_out <= '0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            busy     <= 1'b1;
            r_type   <= ship_type;
            r_idx    <= line_idx;
            r_mirror <= mirror;
            r_cnt    <= '0;
            r_col    <= '0;
            if (rotate) begin
              r_state <= SCAN;
              r_zero  <= w_type_oor || (32'(line_idx) >= PIXEL_W);
            end else begin
              r_state <= READ;
              r_zero  <= w_type_oor || (32'(line_idx) >= LINE_H);
            end
          end
        end
        READ: begin
          line_pixels_out <= r_zero ? '0 : (r_mirror ? w_rom_rev : w_rom_q);
          valid           <= 1'b1;
          r_state         <= OUT;
        end
        SCAN: begin
          // ROM data lags the counter by one cycle, so row r_cnt-1 is captured here.
          if (r_cnt != CNT_W'(LINE_H)) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (r_cnt != '0) begin
            r_col <= w_col_next[LINE_H-2:0];
          end
          if (r_cnt == CNT_W'(LINE_H)) begin
            line_pixels_out <= r_zero ? '0 : (r_mirror ? w_col_mir : w_col_fwd);
            valid           <= 1'b1;
            r_state         <= OUT;
          end
        end
        OUT: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_sprite_rom.sv
// Scoreboard bench for ship_sprite_rom: the stimulus queues expected lines and valid cycles, and a monitor pops and compares them.
// N_SHIPS is set to 3 so that ship_type = N_SHIPS fits in the 2-bit type port.
module tb_ship_sprite_rom;

  localparam int PIXEL_W = 48;
  localparam int LINE_H  = 24;
  localparam int N_SHIPS = 3;
  localparam int IDX_W   = 6;
  localparam int TYPE_W  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req = 1'b0;
  logic [TYPE_W-1:0]  ship_type = '0;
  logic [IDX_W-1:0]   line_idx = '0;
  logic               rotate = 1'b0;
  logic               mirror = 1'b0;
  logic               busy;
  logic               valid;
  logic [PIXEL_W-1:0] line_pixels_out;

  typedef struct {
    logic [PIXEL_W-1:0] data;
    int                 cyc;
    string              name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt = 0;

  ship_sprite_rom #(
    .PIXEL_W (PIXEL_W),
    .LINE_H  (LINE_H),
    .N_SHIPS (N_SHIPS),
    .IDX_W   (IDX_W),
    .TYPE_W  (TYPE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .ship_type       (ship_type),
    .line_idx        (line_idx),
    .rotate          (rotate),
    .mirror          (mirror),
    .busy            (busy),
    .valid           (valid),
    .line_pixels_out (line_pixels_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [PIXEL_W-1:0] got, input logic [PIXEL_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check_val({e.name, "_data"}, line_pixels_out, e.data);
          check_int({e.name, "_cycle"}, cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy got %b expected 0", busy);
    end
  endtask

  // Issue one request from a negedge with busy low. It is therefore accepted at the next posedge.
  task automatic fetch(input logic [TYPE_W-1:0] t, input logic [IDX_W-1:0] idx, input logic rot,
                       input logic mir, input logic [PIXEL_W-1:0] exp, input string name);
    wait_idle();
    ship_type = t;
    line_idx  = idx;
    rotate    = rot;
    mirror    = mir;
    req       = 1'b1;
    sb.push_back('{data: exp, cyc: cyc + (rot ? LINE_H + 2 : 2), name: name});
    @(negedge clk);
    req = 1'b0;
  endtask

  logic [TYPE_W-1:0]  b2b_t   [3] = '{2'd0, 2'd0, 2'd2};
  logic [IDX_W-1:0]   b2b_i   [3] = '{6'd4, 6'd10, 6'd5};
  logic               b2b_m   [3] = '{1'b0, 1'b1, 1'b0};
  logic [PIXEL_W-1:0] b2b_exp [3] = '{48'h000111111000, 48'h000888888000, 48'h0F0F0F0F0F0F};

  initial begin
    int vc;
    int n;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_val("reset_busy", PIXEL_W'(busy), '0);
    check_val("reset_valid", PIXEL_W'(valid), '0);
    check_val("reset_out", line_pixels_out, '0);
    rst = 1'b0;
    @(negedge clk);

    fetch(2'd0, 6'd4,  1'b0, 1'b0, 48'h000111111000, "norm_row4");
    fetch(2'd0, 6'd0,  1'b0, 1'b0, 48'h000000000000, "norm_row0");
    fetch(2'd0, 6'd10, 1'b0, 1'b1, 48'h000888888000, "mirror_row10");
    fetch(2'd0, 6'd35, 1'b1, 1'b0, 48'h1FFFF8000000, "rot_col35");
    fetch(2'd0, 6'd34, 1'b1, 1'b0, 48'h000000000000, "rot_col34");
    fetch(2'd2, 6'd44, 1'b1, 1'b0, 48'h7FE000000000, "rot_t2");
    fetch(2'd2, 6'd44, 1'b1, 1'b1, 48'h0007FE000000, "rot_t2_mirror");
    fetch(2'd2, 6'd5,  1'b0, 1'b1, 48'hF0F0F0F0F0F0, "mirror_t2");
    wait_idle();
    repeat (3) @(negedge clk);
    check_val("hold_between_valid", line_pixels_out, 48'hF0F0F0F0F0F0);
    fetch(2'd3, 6'd4,  1'b0, 1'b0, 48'h000000000000, "oor_type");
    fetch(2'd0, 6'd30, 1'b0, 1'b0, 48'h000000000000, "oor_row");
    fetch(2'd0, 6'd50, 1'b1, 1'b0, 48'h000000000000, "oor_col");

    // Back-to-back: req held high throughout, and a new request is taken every third cycle.
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      ship_type = b2b_t[k];
      line_idx  = b2b_i[k];
      mirror    = b2b_m[k];
      rotate    = 1'b0;
      req       = 1'b1;
      sb.push_back('{data: b2b_exp[k], cyc: cyc + 2, name: "b2b"});
      repeat (3) @(negedge clk);
    end
    req = 1'b0;

    // req stays high during a column scan with changed inputs; only the first one counts.
    wait_idle();
    ship_type = 2'd0;
    line_idx  = 6'd27;
    rotate    = 1'b1;
    mirror    = 1'b0;
    req       = 1'b1;
    sb.push_back('{data: 48'h1FFFF8000000, cyc: cyc + LINE_H + 2, name: "rot_req_spam"});
    @(negedge clk);
    ship_type = 2'd2;
    line_idx  = 6'd4;
    rotate    = 1'b0;
    mirror    = 1'b1;
    repeat (24) @(negedge clk);
    req = 1'b0;

    // Abort a column scan with reset. No valid may follow.
    wait_idle();
    ship_type = 2'd0;
    line_idx  = 6'd35;
    rotate    = 1'b1;
    mirror    = 1'b0;
    req       = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check_val("scan_busy", PIXEL_W'(busy), 48'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", PIXEL_W'(busy), '0);
    check_val("abort_out", line_pixels_out, '0);
    vc = valid_cnt;
    repeat (30) @(negedge clk);
    check_int("abort_no_valid", valid_cnt, vc);

    fetch(2'd0, 6'd4, 1'b0, 1'b0, 48'h000111111000, "after_reset");

    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_int("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
